// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the PC sequencer: FSM state
//               encoding, default reset/trap vectors and the fetch stride.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0180;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_if
// Description : Bundle between the ID-stage control (hazard unit, branch
//               resolution) and the PC sequencer. Statistics signals exist
//               only when PC_SEQ_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_seq_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        if_id_write;
  logic        if_id_flush;
  logic        trap;
  logic        halted;
`ifdef PC_SEQ_STATS_EN
  logic [31:0] stat_cycles;
  logic [31:0] stat_stalls;
  logic [31:0] stat_redirects;
`endif

  // ID-stage side: presents hazard/branch decisions, consumes fetch control
  modport master (
    output stall, redirect, redirect_pc, halt,
    input  pc, fetch_valid, if_id_write, if_id_flush, trap, halted
`ifdef PC_SEQ_STATS_EN
    , input stat_cycles, stat_stalls, stat_redirects
`endif
  );

  // Sequencer side
  modport slave (
    input  stall, redirect, redirect_pc, halt,
    output pc, fetch_valid, if_id_write, if_id_flush, trap, halted
`ifdef PC_SEQ_STATS_EN
    , output stat_cycles, stat_stalls, stat_redirects
`endif
  );

endinterface : pc_seq_if
`default_nettype wire

// File: rtl/pc_seq_stats.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_stats
// Description : Free-running wrap-around event counters for the sequencer:
//               RUN cycles, stalled RUN cycles and accepted redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_stats (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_run_cycle,
  input  wire logic        i_stall_event,
  input  wire logic        i_redirect_event,
  output logic [31:0]      o_stat_cycles,
  output logic [31:0]      o_stat_stalls,
  output logic [31:0]      o_stat_redirects
);

  logic [31:0] r_cycles;
  logic [31:0] r_stalls;
  logic [31:0] r_redirects;

  // Count events; HALT freezes counters because no event strobe fires there
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycles    <= 32'd0;
      r_stalls    <= 32'd0;
      r_redirects <= 32'd0;
    end else begin
      if (i_run_cycle)      r_cycles    <= r_cycles + 32'd1;
      if (i_stall_event)    r_stalls    <= r_stalls + 32'd1;
      if (i_redirect_event) r_redirects <= r_redirects + 32'd1;
    end
  end

  assign o_stat_cycles    = r_cycles;
  assign o_stat_stalls    = r_stalls;
  assign o_stat_redirects = r_redirects;

endmodule : pc_seq_stats
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter owner for the pipelined MIPS core. Chooses
//               sequential advance, hazard hold, branch/jump redirect, trap on
//               misaligned target, or halt, and drives IF/ID control.
//               Optional statistics counters: define PC_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  wire logic clk,
  input  wire logic rst_n,
  pc_seq_if.slave   bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        w_fetch_valid;
  logic        w_if_id_write;
  logic        w_if_id_flush;
  logic        w_trap;
  logic        w_halted;

  // State and PC registers; reset overrides every input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control decode
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_fetch_valid = 1'b0;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b1;
    w_trap        = 1'b0;
    w_halted      = 1'b0;

    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        w_fetch_valid = 1'b1;
        w_if_id_write = !bus.stall;
        w_if_id_flush = 1'b0;
        if (bus.halt) begin
          w_state_nxt   = HALT;
          w_if_id_flush = 1'b1;
        end else if (bus.stall) begin
          // Branch is re-presented by the hazard unit once the stall clears
          w_pc_nxt = r_pc;
        end else if (bus.redirect) begin
          w_if_id_flush = 1'b1;
          if (bus.redirect_pc[1:0] == 2'b00) begin
            w_pc_nxt = bus.redirect_pc;
          end else begin
            w_pc_nxt    = TRAP_PC;
            w_state_nxt = TRAP;
          end
        end else begin
          w_pc_nxt = r_pc + PC_STEP;
        end
      end
      TRAP: begin
        w_trap      = 1'b1;
        w_state_nxt = RUN;
      end
      HALT: begin
        w_if_id_write = 1'b0;
        w_if_id_flush = 1'b0;
        w_halted      = 1'b1;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase

    // While reset is asserted the outputs already look like BOOT
    if (!rst_n) begin
      w_fetch_valid = 1'b0;
      w_if_id_write = 1'b1;
      w_if_id_flush = 1'b1;
      w_trap        = 1'b0;
      w_halted      = 1'b0;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.fetch_valid = w_fetch_valid;
  assign bus.if_id_write = w_if_id_write;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.trap        = w_trap;
  assign bus.halted      = w_halted;

`ifdef PC_SEQ_STATS_EN
  logic w_run_cycle;
  logic w_stall_event;
  logic w_redirect_event;

  // Event strobes mirror the RUN priority chain: halt beats stall beats redirect
  always_comb begin
    w_run_cycle      = (r_state == RUN);
    w_stall_event    = w_run_cycle && bus.stall && !bus.halt;
    w_redirect_event = w_run_cycle && bus.redirect && !bus.stall && !bus.halt;
  end

  pc_seq_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_run_cycle      (w_run_cycle),
    .i_stall_event    (w_stall_event),
    .i_redirect_event (w_redirect_event),
    .o_stat_cycles    (bus.stat_cycles),
    .o_stat_stalls    (bus.stat_stalls),
    .o_stat_redirects (bus.stat_redirects)
  );
`endif

endmodule : pc_sequencer
`default_nettype wire
